// File: rtl/parallel_serial_tx.sv
// Transmit-side serializer: sends bytes MSB first, one bit per clock, behind a
// comma-based alignment preamble, and fills idle byte slots with the comma character.
module parallel_serial_tx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned SYNC_COMMAS = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       VALID_IN,
  output logic       READY_OUT,
  output logic       DATA_OUT,
  output logic       FRAME_OUT,
  output logic       LINK_UP
);

  typedef enum logic {
    SYNC = 1'b0,
    LINK = 1'b1
  } state_t;

  localparam logic [7:0] LAST_COMMA = 8'(SYNC_COMMAS - 1);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] shreg_r;
  logic [7:0] shreg_s;
  logic [7:0] comma_cnt_r;
  logic [7:0] comma_cnt_s;
  logic [2:0] bit_cnt_r;
  logic       data_out_r;
  logic       frame_out_r;
  logic       byte_end_s;
  logic       last_sync_s;

  // Handshake window and status decode, from registered state only
  always_comb begin
    byte_end_s  = (bit_cnt_r == 3'd7);
    last_sync_s = (comma_cnt_r == LAST_COMMA);
    READY_OUT   = byte_end_s && ((state_r == LINK) || last_sync_s);
    LINK_UP     = (state_r == LINK);
    DATA_OUT    = data_out_r;
    FRAME_OUT   = frame_out_r;
  end

  // Next-state, comma counting and byte reload at the LSB edge of each slot
  always_comb begin
    state_s     = state_r;
    comma_cnt_s = comma_cnt_r;
    shreg_s     = shreg_r;
    if (byte_end_s) begin
      if (READY_OUT && VALID_IN) begin
        shreg_s = DATA_IN;
      end else begin
        shreg_s = COMMA;
      end
      case (state_r)
        SYNC: begin
          if (last_sync_s) begin
            state_s = LINK;
          end else begin
            comma_cnt_s = comma_cnt_r + 8'd1;
          end
        end
        LINK:    state_s = LINK;
        default: state_s = SYNC;
      endcase
    end else begin
      shreg_s = shreg_r;
    end
  end

  // State registers and the registered serial/frame outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= SYNC;
      shreg_r     <= COMMA;
      bit_cnt_r   <= 3'd0;
      comma_cnt_r <= 8'd0;
      data_out_r  <= 1'b0;
      frame_out_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      comma_cnt_r <= comma_cnt_s;
      bit_cnt_r   <= bit_cnt_r + 3'd1;
      data_out_r  <= shreg_r[3'd7 - bit_cnt_r];
      frame_out_r <= (bit_cnt_r == 3'd0);
    end
  end

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Scoreboard bench for parallel_serial_tx: the driver queues the expected per-edge
// outputs of each directed scenario, and a monitor checks them after every rising edge.
module tb_parallel_serial_tx;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         NS    = 4;

  typedef struct packed {
    logic d;
    logic f;
    logic r;
    logic l;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DATA_IN;
  logic       VALID_IN;
  logic       READY_OUT;
  logic       DATA_OUT;
  logic       FRAME_OUT;
  logic       LINK_UP;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;

  parallel_serial_tx #(.COMMA(COMMA), .SYNC_COMMAS(NS)) dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .VALID_IN(VALID_IN),
    .READY_OUT(READY_OUT), .DATA_OUT(DATA_OUT), .FRAME_OUT(FRAME_OUT), .LINK_UP(LINK_UP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_no, act, req);
    end
  endtask

  // Monitor: one queued expectation per rising edge, sampled 2 time units after it
  always @(posedge CLK) begin
    exp_t e;
    #2;
    edge_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("DATA_OUT",  DATA_OUT,  e.d);
      chk("FRAME_OUT", FRAME_OUT, e.f);
      chk("READY_OUT", READY_OUT, e.r);
      chk("LINK_UP",   LINK_UP,   e.l);
    end
  end

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  // Slot j after reset release covers edges 8j+1..8j+8
  task automatic push_slot(input int j, input logic [7:0] b, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.d = b[7-i];
      e.f = (i == 0);
      e.r = (i == 6) && (j >= NS - 1);
      e.l = (j > NS - 1) || ((j == NS - 1) && (i == 7));
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    RESET    = 1'b1;
    VALID_IN = 1'b1;
    DATA_IN  = 8'h5A;
    edge_no  = 0;
    push_zero(n);
    step(n);
    RESET    = 1'b0;
    VALID_IN = 1'b0;
    edge_no  = 0;
  endtask

  task automatic push_commas(input int first, input int last);
    for (int j = first; j <= last; j++) push_slot(j, COMMA, 8);
  endtask

  initial begin
    RESET = 1'b1; VALID_IN = 1'b0; DATA_IN = 8'h00;

    // Reset with VALID high, then the plain sync run and following commas
    do_reset(3);
    push_commas(0, 5);
    step(48);

    // Single byte A5 offered from release, taken at edge 32
    do_reset(3);
    VALID_IN = 1'b1; DATA_IN = 8'hA5;
    push_commas(0, 3); push_slot(4, 8'hA5, 8); push_slot(5, COMMA, 8);
    step(32);
    VALID_IN = 1'b0;
    step(16);

    // Back-to-back 00, FF, 3C
    do_reset(3);
    VALID_IN = 1'b1; DATA_IN = 8'h00;
    push_commas(0, 3); push_slot(4, 8'h00, 8); push_slot(5, 8'hFF, 8);
    push_slot(6, 8'h3C, 8); push_slot(7, COMMA, 8);
    step(32); DATA_IN = 8'hFF;
    step(8);  DATA_IN = 8'h3C;
    step(8);  VALID_IN = 1'b0;
    step(16);

    // Idle insertion; VALID during sync (outside the window) is ignored
    do_reset(3);
    VALID_IN = 1'b1; DATA_IN = 8'h55;
    push_commas(0, 5); push_slot(6, 8'h81, 8); push_slot(7, COMMA, 8);
    step(30); VALID_IN = 1'b0;
    step(17); VALID_IN = 1'b1; DATA_IN = 8'h81;
    step(1);  VALID_IN = 1'b0;
    step(16);

    // Mid-byte reset after edge 36 abandons A5 and restarts the comma run
    do_reset(3);
    VALID_IN = 1'b1; DATA_IN = 8'hA5;
    push_commas(0, 3); push_slot(4, 8'hA5, 4);
    push_zero(1);
    push_commas(0, 4);
    step(32); VALID_IN = 1'b0;
    step(4);  RESET = 1'b1;
    step(1);  RESET = 1'b0; edge_no = 0;
    step(40);

    // Reset coinciding with a handshake: the byte is not taken
    do_reset(3);
    push_commas(0, 2); push_slot(3, COMMA, 7);
    push_zero(1);
    push_commas(0, 4);
    step(31); VALID_IN = 1'b1; DATA_IN = 8'hA5; RESET = 1'b1;
    step(1);  RESET = 1'b0; VALID_IN = 1'b0; edge_no = 0;
    step(40);

    step(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
